// File: rtl/vga_param_timing_pal.sv
// vga_param_timing_pal: parametrised VGA timing, border window and palette lookup, with every
//    video output delay-matched to the pixel-fetch latency PIX_LAT.
// Ports:
//    i_pclk, i_rst        pixel clock, asynchronous active-high reset
//    i_pixel              palette index, valid PIX_LAT cycles after the matching o_fetch_en
//    o_px, o_py           fetch coordinates inside the active window (0 outside it)
//    o_fetch_en           o_px/o_py name an active pixel this cycle
//    o_r, o_g, o_b        registered RGB565 colour
//    o_hsync, o_vsync     registered sync, active level set by HS_POL/VS_POL
//    o_drawon, o_borderon colour is an active pixel / the border colour
//    o_frame_start        one-cycle pulse with the first active output pixel of a frame
//    i_pal_we, i_pal_addr, i_pal_data  palette write port, present only when the macro
//                         VGA_PALETTE_WR_EN is defined; otherwise the palette is a constant ROM
module vga_param_timing_pal #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter int unsigned BORDER     = 8,
   parameter logic [15:0] BORDER_RGB = 16'h0000,
   parameter bit          HS_POL     = 1'b0,
   parameter bit          VS_POL     = 1'b0,
   parameter int unsigned PIX_W      = 4,
   parameter int unsigned PIX_LAT    = 1,
   parameter int unsigned CW         = 11
) (
   input  logic             i_pclk,
   input  logic             i_rst,
   input  logic [PIX_W-1:0] i_pixel,
`ifdef VGA_PALETTE_WR_EN
   input  logic             i_pal_we,
   input  logic [PIX_W-1:0] i_pal_addr,
   input  logic [15:0]      i_pal_data,
`endif
   output logic [CW-1:0]    o_px,
   output logic [CW-1:0]    o_py,
   output logic             o_fetch_en,
   output logic [4:0]       o_r,
   output logic [5:0]       o_g,
   output logic [4:0]       o_b,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_drawon,
   output logic             o_borderon,
   output logic             o_frame_start
);
   localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned PAL_N = 2 ** PIX_W;
   localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HT1 = CW'(H_TOT - 1);
   localparam logic [CW-1:0] VT1 = CW'(V_TOT - 1);
   localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS1 = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] HB0 = CW'(H_ACTIVE + BORDER);
   localparam logic [CW-1:0] HB1 = CW'(H_TOT - BORDER);
   localparam logic [CW-1:0] VB0 = CW'(V_ACTIVE + BORDER);
   localparam logic [CW-1:0] VB1 = CW'(V_TOT - BORDER);
   // With no border the trailing-edge bound equals the total and could wrap in CW bits.
   localparam bit HAS_B = BORDER != 0;

   if (BORDER > H_FP || BORDER > H_BP || BORDER > V_FP || BORDER > V_BP) begin : g_bad_border
      $error("BORDER must fit inside every front and back porch");
   end

   function automatic logic [15:0] pal_init(input logic [7:0] i);
      case (i)
         8'd1:    return {5'h00, 6'h00, 5'h0F};
         8'd2:    return {5'h00, 6'h1F, 5'h00};
         8'd3:    return {5'h0F, 6'h00, 5'h00};
         8'd4:    return {5'h00, 6'h1F, 5'h0F};
         8'd5:    return {5'h0F, 6'h00, 5'h0F};
         8'd6:    return {5'h0F, 6'h1F, 5'h00};
         8'd7:    return {5'h0F, 6'h1F, 5'h0F};
         8'd8:    return {5'h07, 6'h0F, 5'h07};
         8'd9:    return {5'h00, 6'h00, 5'h1F};
         8'd10:   return {5'h00, 6'h3F, 5'h00};
         8'd11:   return {5'h1F, 6'h00, 5'h00};
         8'd12:   return {5'h00, 6'h3F, 5'h1F};
         8'd13:   return {5'h1F, 6'h00, 5'h1F};
         8'd14:   return {5'h1F, 6'h3F, 5'h00};
         8'd15:   return {5'h1F, 6'h3F, 5'h1F};
         default: return 16'h0000;
      endcase
   endfunction

   logic [15:0] w_pal_rd;
`ifdef VGA_PALETTE_WR_EN
   logic [15:0] r_pal [PAL_N];
   // Lookups read the registered array, so a same-cycle write is seen only from the next cycle.
   always_ff @(posedge i_pclk or posedge i_rst)
      if (i_rst) for (int i = 0; i < PAL_N; i++) r_pal[i] <= pal_init(8'(i));
      else if (i_pal_we) r_pal[i_pal_addr] <= i_pal_data;
   assign w_pal_rd = r_pal[i_pixel];
`else
   assign w_pal_rd = pal_init(8'(i_pixel));
`endif

   logic [CW-1:0] r_hcnt, r_vcnt;
   logic          w_hend;
   assign w_hend = r_hcnt == HT1;
   always_ff @(posedge i_pclk or posedge i_rst)
      if (i_rst) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else begin
         r_hcnt <= w_hend ? '0 : r_hcnt + 1'b1;
         if (w_hend) r_vcnt <= r_vcnt == VT1 ? '0 : r_vcnt + 1'b1;
      end

   logic w_act, w_bord, w_hs, w_vs, w_first;
   assign w_act   = r_hcnt < HA && r_vcnt < VA;
   assign w_bord  = HAS_B && !w_act && (r_hcnt < HB0 || r_hcnt >= HB1) && (r_vcnt < VB0 || r_vcnt >= VB1);
   assign w_hs    = r_hcnt >= HS0 && r_hcnt < HS1;
   assign w_vs    = r_vcnt >= VS0 && r_vcnt < VS1;
   assign w_first = r_hcnt == '0 && r_vcnt == '0;

   // Stage 0 is the registered fetch stage; stages 1..PIX_LAT track the external fetch latency.
   // Flag order: {active, border, hsync, vsync, first}, syncs held active-high internally.
   logic [4:0]    r_pipe [PIX_LAT+1];
   logic [CW-1:0] r_px, r_py;
   always_ff @(posedge i_pclk or posedge i_rst)
      if (i_rst) begin
         for (int k = 0; k <= PIX_LAT; k++) r_pipe[k] <= '0;
         r_px <= '0;
         r_py <= '0;
      end else begin
         r_pipe[0] <= {w_act, w_bord, w_hs, w_vs, w_first};
         for (int k = 1; k <= PIX_LAT; k++) r_pipe[k] <= r_pipe[k-1];
         r_px <= w_act ? r_hcnt : '0;
         r_py <= w_act ? r_vcnt : '0;
      end

   assign o_fetch_en = r_pipe[0][4];
   assign o_px       = r_px;
   assign o_py       = r_py;

   logic [4:0]  w_last;
   logic [15:0] w_rgb;
   assign w_last = r_pipe[PIX_LAT];
   assign w_rgb  = w_last[4] ? w_pal_rd : w_last[3] ? BORDER_RGB : 16'h0000;

   always_ff @(posedge i_pclk or posedge i_rst)
      if (i_rst) begin
         {o_r, o_g, o_b} <= '0;
         o_hsync         <= ~HS_POL;
         o_vsync         <= ~VS_POL;
         o_drawon        <= 1'b0;
         o_borderon      <= 1'b0;
         o_frame_start   <= 1'b0;
      end else begin
         {o_r, o_g, o_b} <= w_rgb;
         o_hsync         <= HS_POL ? w_last[2] : ~w_last[2];
         o_vsync         <= VS_POL ? w_last[1] : ~w_last[1];
         o_drawon        <= w_last[4];
         o_borderon      <= w_last[3];
         o_frame_start   <= w_last[0];
      end
endmodule
